// File: rtl/matmul_ctrl_param.sv
// Square matrix multiply controller: streams A/B reads, accumulates C = A*B, writes C row-major.
// Define MATMUL_SAT_EN to saturate the accumulator instead of wrapping modulo 2^ACC_W.
module matmul_ctrl_param #(
  parameter int N_LOG2 = 6,
  parameter int DW     = 8,
  parameter int ACC_W  = 22,
  localparam int AW    = 2 * N_LOG2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    a_addr,
  output logic             a_nce,
  input  logic [DW-1:0]    a_rdata,
  output logic [AW-1:0]    b_addr,
  output logic             b_nce,
  input  logic [DW-1:0]    b_rdata,
  output logic [AW-1:0]    c_addr,
  output logic             c_nce,
  output logic             c_nwrt,
  output logic [ACC_W-1:0] c_wdata
);

  localparam int CW = 3 * N_LOG2;
  localparam logic [CW-1:0] CNT_LAST = '1;
  localparam logic [N_LOG2-1:0] K_LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic              drain_q;
  logic [CW-1:0]     cnt;
  logic [N_LOG2-1:0] idx_i, idx_j, idx_k;

  logic              vld_p0, vld_p1;
  logic              first_p0, first_p1;
  logic              last_p0, last_p1;
  logic [AW-1:0]     ij_p0, ij_p1;

  logic [2*DW-1:0]   product_p1;
  logic [ACC_W-1:0]  acc, acc_base, sum_p1;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                input logic [2*DW-1:0]  p);
`ifdef MATMUL_SAT_EN
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(p);
    // Partial sums only grow, so a clamped value stays clamped until the next k==0.
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return a + ACC_W'(p);
`endif
  endfunction

  assign idx_i = cnt[CW-1 -: N_LOG2];
  assign idx_j = cnt[2*N_LOG2-1 -: N_LOG2];
  assign idx_k = cnt[N_LOG2-1:0];

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      drain_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      drain_q <= (state == DRAIN) && !drain_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DRAIN;
      DRAIN:   if (drain_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
    end else if (state == RUN && cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // p0: issue stage, registered memory addresses and enables
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p0 <= 1'b0;
      a_nce  <= 1'b1;
      b_nce  <= 1'b1;
      a_addr <= '0;
      b_addr <= '0;
    end else begin
      vld_p0 <= (state == RUN);
      a_nce  <= (state != RUN);
      b_nce  <= (state != RUN);
      if (state == RUN) begin
        a_addr <= {idx_i, idx_k};
        b_addr <= {idx_k, idx_j};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == RUN) begin
      ij_p0    <= {idx_i, idx_j};
      first_p0 <= (idx_k == '0);
      last_p0  <= (idx_k == K_LAST);
    end
  end

  // p1: memory read cycle, operands arrive at the end of this stage
  always_ff @(posedge clk) begin
    if (!rstn) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    ij_p1    <= ij_p0;
    first_p1 <= first_p0;
    last_p1  <= last_p0;
  end

  assign product_p1 = (2*DW)'(a_rdata) * (2*DW)'(b_rdata);
  assign acc_base   = first_p1 ? '0 : acc;
  assign sum_p1     = acc_add(acc_base, product_p1);

  // p2: accumulate, and register the finished element for the C write
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc     <= '0;
      c_wdata <= '0;
      c_addr  <= '0;
      c_nce   <= 1'b1;
      c_nwrt  <= 1'b1;
    end else begin
      c_nce  <= 1'b1;
      c_nwrt <= 1'b1;
      if (vld_p1) begin
        acc <= sum_p1;
        if (last_p1) begin
          c_wdata <= sum_p1;
          c_addr  <= ij_p1;
          c_nce   <= 1'b0;
          c_nwrt  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_ctrl_param.sv
// Bench for matmul_ctrl_param at N=4: vector table of matrix patterns plus start/reset corner sequences.
module tb_matmul_ctrl_param;

  localparam int N_LOG2 = 2;
  localparam int DW     = 8;
  localparam int ACC_W  = 16;
  localparam int AW     = 2 * N_LOG2;
  localparam int N      = 1 << N_LOG2;
  localparam int NN     = N * N;
  localparam int LAT    = N * N * N + 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             busy, done;
  logic [AW-1:0]    a_addr, b_addr, c_addr;
  logic             a_nce, b_nce, c_nce, c_nwrt;
  logic [DW-1:0]    a_rdata, b_rdata;
  logic [ACC_W-1:0] c_wdata;

  matmul_ctrl_param #(.N_LOG2(N_LOG2), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .a_addr(a_addr), .a_nce(a_nce), .a_rdata(a_rdata),
    .b_addr(b_addr), .b_nce(b_nce), .b_rdata(b_rdata),
    .c_addr(c_addr), .c_nce(c_nce), .c_nwrt(c_nwrt), .c_wdata(c_wdata)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [DW-1:0] mem_a [NN];
  logic [DW-1:0] mem_b [NN];
  longint        ref_c [NN];

  always @(posedge clk) begin
    if (!a_nce) a_rdata <= mem_a[a_addr];
    if (!b_nce) b_rdata <= mem_b[b_addr];
  end

  int wr_edge[$], wr_addr[$], wr_data[$], done_edge[$];
  always @(negedge clk) begin
    if (!c_nce && !c_nwrt) begin
      wr_edge.push_back(edge_cnt);
      wr_addr.push_back(int'(c_addr));
      wr_data.push_back(int'(c_wdata));
    end
    if (done) done_edge.push_back(edge_cnt);
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_edge.delete(); wr_addr.delete(); wr_data.delete(); done_edge.delete();
  endtask

  task automatic fill(input int pat);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (pat)
          0: begin mem_a[r*N+c] = (r == c) ? 8'd1 : 8'd0; mem_b[r*N+c] = 8'(4*r + c); end
          1: begin mem_a[r*N+c] = 8'hFF; mem_b[r*N+c] = 8'hFF; end
          2: begin mem_a[r*N+c] = 8'($urandom_range(0, 255)); mem_b[r*N+c] = 8'($urandom_range(0, 255)); end
          3: begin mem_a[r*N+c] = 8'd0; mem_b[r*N+c] = 8'd0; end
          default: begin mem_a[r*N+c] = 8'($urandom_range(180, 255)); mem_b[r*N+c] = 8'($urandom_range(180, 255)); end
        endcase
      end
    end
  endtask

  // Reference: exact integer dot products, then reduced to the accumulator's range.
  task automatic compute_ref();
    longint s;
    longint maxv;
    maxv = (longint'(1) << ACC_W) - 1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += longint'(mem_a[i*N+k]) * longint'(mem_b[k*N+j]);
`ifdef MATMUL_SAT_EN
        ref_c[i*N+j] = (s > maxv) ? maxv : s;
`else
        ref_c[i*N+j] = s % (longint'(1) << ACC_W);
`endif
      end
    end
  endtask

  task automatic start_run(output int s_edge);
    tick();
    start  = 1'b1;
    s_edge = edge_cnt + 1;
    tick();
    start  = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int count, input int limit);
    int n;
    n = 0;
    while (done_edge.size() < count && n < limit) begin
      tick();
      n++;
    end
    if (done_edge.size() < count) check("done_timeout", done_edge.size(), count);
  endtask

  task automatic check_writes(input string tag, input int base, input int cnt);
    for (int n = 0; n < cnt && base + n < wr_addr.size(); n++) begin
      check($sformatf("%s_addr%0d", tag, n), wr_addr[base+n], n);
      check($sformatf("%s_data%0d", tag, n), wr_data[base+n], ref_c[n]);
      if (n > 0)
        check($sformatf("%s_gap%0d", tag, n), wr_edge[base+n] - wr_edge[base+n-1], N);
    end
  endtask

  task automatic check_run(input string tag, input int s_edge, input int exp_clast);
    check({tag, "_done_count"}, done_edge.size(), 1);
    check({tag, "_write_count"}, wr_addr.size(), NN);
    if (done_edge.size() > 0) begin
      check({tag, "_done_latency"}, done_edge[0] - s_edge, LAT);
      if (wr_edge.size() > 0)
        check({tag, "_last_write_at_done"}, wr_edge[wr_edge.size()-1], done_edge[0]);
    end
    check({tag, "_busy_idle"}, busy, 0);
    check_writes(tag, 0, NN);
    if (exp_clast >= 0 && wr_data.size() == NN)
      check({tag, "_c_last"}, wr_data[NN-1], exp_clast);
  endtask

  typedef struct {
    int pat;
    int exp_clast;
  } vec_t;

  vec_t vecs[6];
  int   s_edge, d0, n;

  initial begin
    vecs[0] = '{pat: 0, exp_clast: 15};
`ifdef MATMUL_SAT_EN
    vecs[1] = '{pat: 1, exp_clast: 65535};
`else
    vecs[1] = '{pat: 1, exp_clast: (4 * 255 * 255) % 65536};
`endif
    vecs[2] = '{pat: 3, exp_clast: 0};
    vecs[3] = '{pat: 2, exp_clast: -1};
    vecs[4] = '{pat: 4, exp_clast: -1};
    vecs[5] = '{pat: 2, exp_clast: -1};

    a_rdata = '0;
    b_rdata = '0;
    fill(3);
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_a_nce", a_nce, 1);
    check("rst_b_nce", b_nce, 1);
    check("rst_c_nce", c_nce, 1);
    check("rst_c_nwrt", c_nwrt, 1);
    check("rst_a_addr", a_addr, 0);
    check("rst_c_wdata", c_wdata, 0);
    rstn = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].pat);
      compute_ref();
      clear_logs();
      start_run(s_edge);
      wait_done(1, LAT + 20);
      repeat (3) tick();
      check_run($sformatf("vec%0d", v), s_edge, vecs[v].exp_clast);
    end

    // Start pulsed again mid-run must not disturb the run.
    fill(2);
    compute_ref();
    clear_logs();
    start_run(s_edge);
    while (edge_cnt < s_edge + 10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, LAT + 20);
    repeat (3) tick();
    check_run("restart_ignored", s_edge, -1);

    // Start held high through DONE launches the next run at the first IDLE cycle.
    fill(4);
    compute_ref();
    clear_logs();
    tick();
    start = 1'b1;
    wait_done(1, LAT + 20);
    if (done_edge.size() > 0) begin
      d0 = done_edge[0];
      n = 0;
      while (edge_cnt < d0 + 2 && n < 10) begin tick(); n++; end
    end
    start = 1'b0;
    wait_done(2, LAT + 20);
    repeat (3) tick();
    check("held_done_count", done_edge.size(), 2);
    if (done_edge.size() == 2)
      check("held_done_spacing", done_edge[1] - done_edge[0], LAT + 2);
    check("held_write_count", wr_addr.size(), 2 * NN);
    if (wr_addr.size() == 2 * NN) check_writes("held_run2", NN, NN);

    // Reset for one cycle while index 20 is issuing.
    fill(2);
    compute_ref();
    clear_logs();
    start_run(s_edge);
    while (edge_cnt < s_edge + 20) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("midrst_a_nce", a_nce, 1);
    check("midrst_b_nce", b_nce, 1);
    check("midrst_c_nce", c_nce, 1);
    check("midrst_c_nwrt", c_nwrt, 1);
    check("midrst_busy", busy, 0);
    repeat (LAT + 10) tick();
    check("midrst_no_done", done_edge.size(), 0);
    check("midrst_writes_before_abort", wr_addr.size(), 4);
    clear_logs();
    start_run(s_edge);
    wait_done(1, LAT + 20);
    repeat (3) tick();
    check_run("after_rst", s_edge, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
